calc_cmd_queue: RTL and testbench
=================================

Name: calc_cmd_queue

Overview:
- Sits between the five button `denoise` stages and `calc`. It turns single-cycle button pulses into `calc` instruction words.
- Instructions are buffered in a small FIFO and issued to `calc` one at a time, only while `calc_ready` is high.
- Replaces the direct button-to-`calc_instr` logic in the top level, so presses made while `calc` is busy are no longer lost.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- HOLDOFF, 2, cycles after an issue during which `calc_ready` is ignored; covers `calc`'s ready-deassert latency. Range 1..15.

Ports:
- clk  in  1  system clock (PLL CLKOUT0).
- rst_n  in  1  asynchronous active-low reset.
- btn_pulse  in  5  one-cycle pulses {U,C,L,R,D}, bit4 = U, bit0 = D.
- sw  in  16  switch value; sampled in the pulse cycle.
- calc_ready  in  1  `calc` can accept an instruction.
- calc_instr  out  32  instruction to `calc`. [31:28] = 0 means no-op.
- fifo_count  out  7  entries currently queued (0..DEPTH).
- drop_cnt  out  8  saturating count of pulses lost.

Behaviour:
- Reset (async assert, sync release):
  - calc_instr = 0, fifo_count = 0, drop_cnt = 0.
  - FSM = IDLE; FIFO pointers = 0.
  - Reset mid-operation discards all queued entries immediately.
- Encoding (combinational from btn_pulse and sw):
  - U → {4'hC, 28'h0}
  - C → {4'hB, sw, 12'h0}
  - L → {4'h8, 28'h0}
  - R → {4'h9, 28'h0}
  - D → {4'hD, 28'h0}
- Simultaneous pulses:
  - Priority U > C > L > R > D; only the highest is enqueued.
  - Each other set bit increments drop_cnt in the same cycle (saturating at 255).
- Enqueue:
  - Any pulse bit high and FIFO not full → write at wptr on that clk edge.
  - The entry is visible in fifo_count the next cycle.
  - FIFO full with no dequeue that cycle → entry dropped, drop_cnt += 1 (plus any lower-priority drops).
  - Full with a dequeue in the same cycle → write accepted; count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are decided from fifo_count, not pointer equality.
- FSM:
  - IDLE: if FIFO not empty and calc_ready=1 → pop head, drive calc_instr = head, go ISSUE. Otherwise calc_instr[31:28] = 0.
  - ISSUE (1 cycle): calc_instr returns to 0 (the whole word is cleared); load holdoff counter with HOLDOFF-1; go HOLD.
  - HOLD: counter decrements each cycle; at 0 → IDLE. calc_ready is ignored throughout.
- Issue properties:
  - calc_instr carries a non-zero opcode for exactly one cycle per issued entry.
  - Minimum spacing between issues is HOLDOFF+2 cycles.
  - Latency: pulse at edge N, FIFO empty, FSM IDLE, calc_ready high → calc_instr valid after edge N+1, held one cycle.
- Ordering is strict FIFO; no reordering, coalescing or duplication.
- calc_ready low in IDLE → entries wait indefinitely; no timeout.

Test Plan:
- Reset, calc_ready=1, sw=16'h1234, single C pulse → one cycle after the pulse edge calc_instr=32'hB123_4000 for exactly 1 cycle, then 0; fifo_count 1→0; drop_cnt=0.
- calc_ready=0, pulses U,L,R,D,C(sw=16'hBEEF) on separate cycles, then calc_ready=1 → issued in order C000_0000, 8000_0000, 9000_0000, D000_0000, BBEE_F000, spaced exactly HOLDOFF+2=4 cycles; fifo_count peaks at 5.
- calc_ready=0, 10 single pulses with DEPTH=8 → fifo_count=8, drop_cnt=2; after release, exactly 8 issues.
- Same-cycle btn_pulse=5'b10101 with FIFO empty → only C000_0000 queued; drop_cnt=2.
- FIFO full with calc_ready=1 and pulse arriving on the pop cycle → entry accepted, fifo_count stays 8, drop_cnt unchanged; assert rst_n low mid-HOLD → calc_instr=0, fifo_count=0 asynchronously, and no issue after release until a new pulse.

Source files
------------

// File: rtl/calc_cmd_queue.sv
// Button-pulse to calc instruction encoder with a FIFO buffer and a paced issue FSM.
// Entries are issued one per calc_ready window, with a holdoff after each issue.
module calc_cmd_queue #(
  parameter int DEPTH   = 8,
  parameter int HOLDOFF = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  btn_pulse,
  input  logic [15:0] sw,
  input  logic        calc_ready,
  output logic [31:0] calc_instr,
  output logic [6:0]  fifo_count,
  output logic [7:0]  drop_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] FULL_CNT  = 7'(DEPTH);
  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [6:0]    r_count;
  logic [7:0]    r_drop;
  logic [1:0]    r_state;
  logic [3:0]    r_hold;
  logic [31:0]   r_instr;

  logic [31:0] w_word;
  logic [2:0]  w_nbits;
  logic [2:0]  w_ndrop;
  logic [8:0]  w_drop_sum;
  logic        w_any;
  logic        w_full;
  logic        w_pop;
  logic        w_push;

  // Highest-priority pulse wins; every other set bit counts as a drop.
  always_comb begin
    w_word = '0;
    if (btn_pulse[4])      w_word = {4'hC, 28'h0};
    else if (btn_pulse[3]) w_word = {4'hB, sw, 12'h0};
    else if (btn_pulse[2]) w_word = {4'h8, 28'h0};
    else if (btn_pulse[1]) w_word = {4'h9, 28'h0};
    else if (btn_pulse[0]) w_word = {4'hD, 28'h0};

    w_nbits = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      w_nbits = w_nbits + 3'(btn_pulse[i]);
    end

    w_any      = |btn_pulse;
    w_full     = (r_count == FULL_CNT);
    w_pop      = (r_state == S_IDLE) && (r_count != '0) && calc_ready;
    w_push     = w_any && (!w_full || w_pop);
    w_ndrop    = w_nbits - 3'(w_push);
    w_drop_sum = {1'b0, r_drop} + 9'(w_ndrop);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= w_word;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_drop  <= '0;
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_instr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      r_count <= r_count + 7'(w_push) - 7'(w_pop);
      r_drop  <= (w_drop_sum > 9'd255) ? 8'hFF : w_drop_sum[7:0];

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_instr <= r_mem[r_rptr];
            r_rptr  <= r_rptr + AW'(1);
            r_state <= S_ISSUE;
          end else begin
            r_instr <= '0;
          end
        end
        S_ISSUE: begin
          r_instr <= '0;
          r_hold  <= HOLD_INIT;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          r_instr <= '0;
          if (r_hold == '0) r_state <= S_IDLE;
          else              r_hold  <= r_hold - 4'd1;
        end
        default: begin
          r_instr <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign calc_instr = r_instr;
  assign fifo_count = r_count;
  assign drop_cnt   = r_drop;

endmodule

// File: tb/tb_calc_cmd_queue.sv
// Self-checking bench for calc_cmd_queue against a queue-based reference model.
module tb_calc_cmd_queue;

  localparam int DEPTH   = 8;
  localparam int HOLDOFF = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  btn_pulse;
  logic [15:0] sw;
  logic        calc_ready;
  logic [31:0] calc_instr;
  logic [6:0]  fifo_count;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: queued words, drop total, earliest cycle the next issue may happen.
  logic [31:0] mq[$];
  int          m_drop;
  int          m_cyc;
  int          m_next;
  logic [31:0] m_instr;

  calc_cmd_queue #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn_pulse  (btn_pulse),
    .sw         (sw),
    .calc_ready (calc_ready),
    .calc_instr (calc_instr),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [4:0] p, input logic [15:0] s);
    if (p[4]) return 32'hC000_0000;
    if (p[3]) return {4'hB, s, 12'h000};
    if (p[2]) return 32'h8000_0000;
    if (p[1]) return 32'h9000_0000;
    return 32'hD000_0000;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_drop  = 0;
    m_cyc   = 0;
    m_next  = 0;
    m_instr = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; btn_pulse = '0; sw = '0; calc_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Apply one cycle of inputs, advance the model over the same edge, return at edge+1.
  task automatic drive(input logic [4:0] p, input logic [15:0] s, input logic r);
    int  sz;
    bit  pop;
    bit  acc;
    int  d;
    btn_pulse = p; sw = s; calc_ready = r;
    @(posedge clk);
    sz  = mq.size();
    pop = (sz > 0) && r && (m_cyc >= m_next);
    if (pop) begin
      m_instr = mq.pop_front();
      m_next  = m_cyc + HOLDOFF + 2;
    end else begin
      m_instr = '0;
    end
    if (p != '0) begin
      acc = (sz < DEPTH) || pop;
      d   = $countones(p) - (acc ? 1 : 0);
      if (acc) mq.push_back(enc(p, s));
      m_drop = (m_drop + d > 255) ? 255 : m_drop + d;
    end
    m_cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; btn_pulse = '0; sw = '0; calc_ready = 1'b0;
    #3;
    checks++;
    if (calc_instr !== 32'h0 || fifo_count !== 7'd0 || drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: instr=%h count=%0d drop=%0d, required 0/0/0",
               calc_instr, fifo_count, drop_cnt);
    end
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive('0, 16'hFFFF, 1'b1);
      checks++;
      if (calc_instr !== 32'h0 || fifo_count !== 7'd0) begin
        errors++;
        $display("FAIL reset_idle: cyc %0d instr=%h count=%0d, required 0/0", i, calc_instr, fifo_count);
      end
    end
  endtask

  task automatic test_single_c();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive((i == 0) ? 5'b01000 : 5'b0, 16'h1234, 1'b1);
      checks++;
      if (calc_instr !== m_instr || fifo_count !== 7'(mq.size()) || drop_cnt !== 8'(m_drop)) begin
        errors++;
        $display("FAIL single_c_model: cyc %0d got %h/%0d/%0d, required %h/%0d/%0d",
                 i, calc_instr, fifo_count, drop_cnt, m_instr, mq.size(), m_drop);
      end
      if (i == 0) begin
        checks++;
        if (fifo_count !== 7'd1) begin
          errors++; $display("FAIL single_c_count: got %0d, required 1", fifo_count);
        end
      end
      if (i == 1) begin
        checks++;
        if (calc_instr !== 32'hB123_4000 || fifo_count !== 7'd0) begin
          errors++; $display("FAIL single_c_issue: got %h/%0d, required b1234000/0", calc_instr, fifo_count);
        end
      end
      if (i == 2) begin
        checks++;
        if (calc_instr !== 32'h0) begin
          errors++; $display("FAIL single_c_clear: got %h, required 0", calc_instr);
        end
      end
    end
  endtask

  task automatic test_order();
    logic [31:0] exp_w [5];
    logic [4:0]  pat   [5];
    int          icyc  [5];
    logic [31:0] iw    [5];
    int          n;
    int          peak;
    exp_w = '{32'hC000_0000, 32'h8000_0000, 32'h9000_0000, 32'hD000_0000, 32'hBBEE_F000};
    pat   = '{5'b10000, 5'b00100, 5'b00010, 5'b00001, 5'b01000};
    n = 0; peak = 0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(pat[i], 16'hBEEF, 1'b0);
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    for (int i = 0; i < 24; i++) begin
      drive('0, 16'h0, 1'b1);
      checks++;
      if (calc_instr !== m_instr || fifo_count !== 7'(mq.size())) begin
        errors++;
        $display("FAIL order_model: cyc %0d got %h/%0d, required %h/%0d",
                 i, calc_instr, fifo_count, m_instr, mq.size());
      end
      if (calc_instr[31:28] != 4'h0 && n < 5) begin
        icyc[n] = i; iw[n] = calc_instr; n++;
      end
    end
    checks++;
    if (peak !== 5 || n !== 5) begin
      errors++; $display("FAIL order_counts: peak=%0d issues=%0d, required 5/5", peak, n);
    end
    for (int k = 0; k < n; k++) begin
      checks++;
      if (iw[k] !== exp_w[k] || (k > 0 && icyc[k] - icyc[k-1] != HOLDOFF + 2)) begin
        errors++;
        $display("FAIL order_issue%0d: word=%h cyc=%0d, required %h spacing %0d",
                 k, iw[k], icyc[k], exp_w[k], HOLDOFF + 2);
      end
    end
  endtask

  task automatic test_overflow();
    int nissue;
    nissue = 0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(5'b00001 << $urandom_range(0, 4), 16'($urandom), 1'b0);
      drive('0, 16'h0, 1'b0);
    end
    checks++;
    if (fifo_count !== 7'd8 || drop_cnt !== 8'd2) begin
      errors++; $display("FAIL overflow_fill: count=%0d drop=%0d, required 8/2", fifo_count, drop_cnt);
    end
    for (int i = 0; i < 8 * (HOLDOFF + 2) + 8; i++) begin
      drive('0, 16'h0, 1'b1);
      checks++;
      if (calc_instr !== m_instr) begin
        errors++; $display("FAIL overflow_model: cyc %0d got %h, required %h", i, calc_instr, m_instr);
      end
      if (calc_instr[31:28] != 4'h0) nissue++;
    end
    checks++;
    if (nissue !== 8 || fifo_count !== 7'd0) begin
      errors++; $display("FAIL overflow_issues: issues=%0d count=%0d, required 8/0", nissue, fifo_count);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(5'b10101, 16'hAAAA, 1'b0);
    checks++;
    if (fifo_count !== 7'd1 || drop_cnt !== 8'd2) begin
      errors++; $display("FAIL simul_queue: count=%0d drop=%0d, required 1/2", fifo_count, drop_cnt);
    end
    drive('0, 16'h0, 1'b1);
    checks++;
    if (calc_instr !== 32'hC000_0000 || fifo_count !== 7'd0) begin
      errors++; $display("FAIL simul_issue: got %h/%0d, required c0000000/0", calc_instr, fifo_count);
    end
  endtask

  task automatic test_full_pop_reset();
    do_reset();
    for (int i = 0; i < DEPTH; i++) drive(5'b00010, 16'h0, 1'b0);
    drive(5'b01000, 16'h5A5A, 1'b1);
    checks++;
    if (fifo_count !== 7'd8 || drop_cnt !== 8'd0 || calc_instr !== 32'h9000_0000) begin
      errors++;
      $display("FAIL full_pop: count=%0d drop=%0d instr=%h, required 8/0/90000000",
               fifo_count, drop_cnt, calc_instr);
    end
    drive('0, 16'h0, 1'b1);
    drive('0, 16'h0, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (calc_instr !== 32'h0 || fifo_count !== 7'd0) begin
      errors++; $display("FAIL async_reset: instr=%h count=%0d, required 0/0", calc_instr, fifo_count);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      drive('0, 16'h0, 1'b1);
      checks++;
      if (calc_instr !== 32'h0 || fifo_count !== 7'd0) begin
        errors++;
        $display("FAIL post_reset_idle: cyc %0d instr=%h count=%0d, required 0/0", i, calc_instr, fifo_count);
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 60; i++) drive(5'b11111, 16'h0, 1'b0);
    checks++;
    if (drop_cnt !== 8'd255 || drop_cnt !== 8'(m_drop)) begin
      errors++; $display("FAIL drop_saturate: got %0d, required 255", drop_cnt);
    end
  endtask

  task automatic test_random();
    logic [4:0] p;
    int         sel;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 5)       p = '0;
      else if (sel < 9)  p = 5'b00001 << $urandom_range(0, 4);
      else               p = 5'($urandom);
      drive(p, 16'($urandom), ($urandom_range(0, 3) != 0));
      checks++;
      if (calc_instr !== m_instr || fifo_count !== 7'(mq.size()) || drop_cnt !== 8'(m_drop)) begin
        errors++;
        $display("FAIL random_model: cyc %0d got %h/%0d/%0d, required %h/%0d/%0d",
                 i, calc_instr, fifo_count, drop_cnt, m_instr, mq.size(), m_drop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_c();
    test_order();
    test_overflow();
    test_simultaneous();
    test_full_pop_reset();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
